// File: rtl/shift_stage.sv
// Buffered shift unit: one 9-bit operand plus shift command per push, results queued in a
// small circular FIFO. Optional saturation statistics when SHIFT_STAGE_STATS_EN is defined.
module shift_stage #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [3:0]               in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   out_count
`ifdef SHIFT_STAGE_STATS_EN
   ,output logic [15:0]              sat_cnt,
    output logic [0:0]               last_sat
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SLA = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    ready_en;
    logic                    push;
    logic                    pop;
    logic                    amt_sat;
    logic signed [WIDTH-1:0] asr_result;
    logic [WIDTH-1:0]        shift_result;

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    assign amt_sat = (int'(in_amt) >= WIDTH);

    // NOTE: the arithmetic shift is kept in its own signed assignment; inside a ?: with an
    // unsigned operand the whole expression turns unsigned and >>> silently becomes >>.
    assign asr_result = $signed(in_data) >>> in_amt;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves it unassigned,
        // which would otherwise infer a latch.
        shift_result = in_data;
        unique case (shift_op_e'(in_op))
            OP_SLL, OP_SLA: shift_result = amt_sat ? '0 : (in_data << in_amt);
            OP_SRL:         shift_result = amt_sat ? '0 : (in_data >> in_amt);
            OP_SRA:         shift_result = amt_sat ? {WIDTH{in_data[WIDTH-1]}}
                                                   : asr_result;
            default:        shift_result = in_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // ready_en keeps in_ready low through reset and until the first edge after release.
    assign in_ready  = ready_en && (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_count = count;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the data array has no reset; validity is carried entirely by count, so clearing
    // the pointers is enough to discard in-flight entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_result;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SHIFT_STAGE_STATS_EN
    // ------------------------------------------------------------------
    // Saturation statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt  <= '0;
            last_sat <= '0;
        end else if (push) begin
            last_sat <= amt_sat;
            if (amt_sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
